// File: rtl/mips8_control_fsm.sv
// -----------------------------------------------------------------------------
// mips8_control_fsm
// Multicycle main controller for the 8-bit MIPS datapath. It fetches a 32-bit
// instruction one byte per cycle (FETCH1..FETCH4), decodes it, and then steps
// through the execute/memory/writeback states of that instruction class. All
// datapath enables, mux selects and the ALU control code are Moore outputs
// decoded from the current state. The one exception is pcen, which also
// depends combinationally on the ALU zero flag so that a branch can qualify
// the PC load.
//
// Ports:
//   clk        in   rising-edge system clock
//   reset      in   asynchronous, active-high reset (forces FETCH1)
//   op         in   instr[31:26] from the IR
//   funct      in   instr[5:0] from the IR
//   zero       in   ALU zero flag
//   memread    out  memory read strobe
//   memwrite   out  memory write strobe
//   alusrca    out  ALU A select: 0=PC, 1=regA
//   alusrcb    out  ALU B select: 00=regB, 01=const 1, 10=imm, 11=branch imm
//   memtoreg   out  regfile write data: 0=ALUout, 1=MDR
//   regdst     out  regfile write register: 0=rt, 1=rd
//   iord       out  memory address: 0=PC, 1=ALUout
//   regwrite   out  regfile write enable
//   irwrite    out  one-hot IR byte load enable
//   pcsrc      out  PC source: 00=ALU result, 01=ALUout, 10=jump target
//   pcen       out  PC load enable
//   branch     out  conditional PC write (BEQEX only)
//   alucontrol out  ALU operation code
//   state      out  current state encoding (debug)
// -----------------------------------------------------------------------------
module mips8_control_fsm #(
  parameter logic [5:0] OP_RTYPE = 6'b000000,
  parameter logic [5:0] OP_LB    = 6'b100000,
  parameter logic [5:0] OP_SB    = 6'b101000,
  parameter logic [5:0] OP_BEQ   = 6'b000100,
  parameter logic [5:0] OP_J     = 6'b000010,
  parameter logic [5:0] OP_ADDI  = 6'b001000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic       memread,
  output logic       memwrite,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic       memtoreg,
  output logic       regdst,
  output logic       iord,
  output logic       regwrite,
  output logic [3:0] irwrite,
  output logic [1:0] pcsrc,
  output logic       pcen,
  output logic       branch,
  output logic [2:0] alucontrol,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    S_FETCH1  = 4'd0,
    S_FETCH2  = 4'd1,
    S_FETCH3  = 4'd2,
    S_FETCH4  = 4'd3,
    S_DECODE  = 4'd4,
    S_MEMADR  = 4'd5,
    S_LBRD    = 4'd6,
    S_LBWR    = 4'd7,
    S_SBWR    = 4'd8,
    S_RTYPEEX = 4'd9,
    S_RTYPEWR = 4'd10,
    S_BEQEX   = 4'd11,
    S_JEX     = 4'd12,
    S_ADDIEX  = 4'd13,
    S_ADDIWR  = 4'd14
  } state_t;

  state_t r_state;

  // Decoded controls before reset gating
  logic       w_memread;
  logic       w_memwrite;
  logic       w_alusrca;
  logic [1:0] w_alusrcb;
  logic       w_memtoreg;
  logic       w_regdst;
  logic       w_iord;
  logic       w_regwrite;
  logic [3:0] w_irwrite;
  logic [1:0] w_pcsrc;
  logic       w_pcwrite;
  logic       w_pcwritecond;
  logic [1:0] w_aluop;
  logic [2:0] w_alucontrol;

  // ALU decoder: aluop 00 add, 01 sub, 10 from funct; funct codes outside the
  // supported set fall back to 101 so the datapath sees a distinct code.
  function automatic logic [2:0] alu_decode(input logic [1:0] aluop,
                                            input logic [5:0] fn);
    logic [2:0] code;
    case (aluop)
      2'b00: code = 3'b010;
      2'b01: code = 3'b110;
      2'b10: begin
        case (fn)
          6'b100000: code = 3'b010;
          6'b100010: code = 3'b110;
          6'b100100: code = 3'b000;
          6'b100101: code = 3'b001;
          6'b101010: code = 3'b111;
          default:   code = 3'b101;
        endcase
      end
      default: code = 3'b010;
    endcase
    return code;
  endfunction

  // State register and next-state sequencing
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_FETCH1;
    end else begin
      case (r_state)
        S_FETCH1:  r_state <= S_FETCH2;
        S_FETCH2:  r_state <= S_FETCH3;
        S_FETCH3:  r_state <= S_FETCH4;
        S_FETCH4:  r_state <= S_DECODE;
        S_DECODE: begin
          case (op)
            OP_LB, OP_SB: r_state <= S_MEMADR;
            OP_RTYPE:     r_state <= S_RTYPEEX;
            OP_BEQ:       r_state <= S_BEQEX;
            OP_J:         r_state <= S_JEX;
            OP_ADDI:      r_state <= S_ADDIEX;
            default:      r_state <= S_FETCH1;
          endcase
        end
        S_MEMADR:  r_state <= (op == OP_LB) ? S_LBRD : S_SBWR;
        S_LBRD:    r_state <= S_LBWR;
        S_RTYPEEX: r_state <= S_RTYPEWR;
        S_ADDIEX:  r_state <= S_ADDIWR;
        // LBWR, SBWR, RTYPEWR, BEQEX, JEX, ADDIWR and the unused code 15
        default:   r_state <= S_FETCH1;
      endcase
    end
  end

  // Moore decode of datapath controls from the current state
  always_comb begin
    w_memread     = 1'b0;
    w_memwrite    = 1'b0;
    w_alusrca     = 1'b0;
    w_alusrcb     = 2'b00;
    w_memtoreg    = 1'b0;
    w_regdst      = 1'b0;
    w_iord        = 1'b0;
    w_regwrite    = 1'b0;
    w_irwrite     = 4'b0000;
    w_pcsrc       = 2'b00;
    w_pcwrite     = 1'b0;
    w_pcwritecond = 1'b0;
    w_aluop       = 2'b00;
    case (r_state)
      S_FETCH1, S_FETCH2, S_FETCH3, S_FETCH4: begin
        w_memread = 1'b1;
        w_alusrcb = 2'b01;
        w_pcwrite = 1'b1;
        // FETCHn is encoded as n-1, so the low bits pick the IR byte lane
        w_irwrite = 4'b0001 << r_state[1:0];
      end
      S_DECODE:  w_alusrcb = 2'b11;
      S_MEMADR: begin
        w_alusrca = 1'b1;
        w_alusrcb = 2'b10;
      end
      S_LBRD: begin
        w_memread = 1'b1;
        w_iord    = 1'b1;
      end
      S_LBWR: begin
        w_regwrite = 1'b1;
        w_memtoreg = 1'b1;
      end
      S_SBWR: begin
        w_memwrite = 1'b1;
        w_iord     = 1'b1;
      end
      S_RTYPEEX: begin
        w_alusrca = 1'b1;
        w_aluop   = 2'b10;
      end
      S_RTYPEWR: begin
        w_regwrite = 1'b1;
        w_regdst   = 1'b1;
      end
      S_BEQEX: begin
        w_alusrca     = 1'b1;
        w_aluop       = 2'b01;
        w_pcwritecond = 1'b1;
        w_pcsrc       = 2'b01;
      end
      S_JEX: begin
        w_pcwrite = 1'b1;
        w_pcsrc   = 2'b10;
      end
      S_ADDIEX: begin
        w_alusrca = 1'b1;
        w_alusrcb = 2'b10;
      end
      S_ADDIWR:  w_regwrite = 1'b1;
      default: begin
        w_memread = 1'b0;
      end
    endcase
    w_alucontrol = alu_decode(w_aluop, funct);
  end

  // Reset is applied combinationally to the outputs so that no strobe (and in
  // particular no write) is visible while reset is held, even though the
  // FETCH1 state itself would otherwise assert memread/irwrite/pcen.
  assign memread    = w_memread  & ~reset;
  assign memwrite   = w_memwrite & ~reset;
  assign alusrca    = w_alusrca  & ~reset;
  assign alusrcb    = reset ? 2'b00 : w_alusrcb;
  assign memtoreg   = w_memtoreg & ~reset;
  assign regdst     = w_regdst   & ~reset;
  assign iord       = w_iord     & ~reset;
  assign regwrite   = w_regwrite & ~reset;
  assign irwrite    = reset ? 4'b0000 : w_irwrite;
  assign pcsrc      = reset ? 2'b00 : w_pcsrc;
  assign pcen       = (w_pcwrite | (w_pcwritecond & zero)) & ~reset;
  assign branch     = w_pcwritecond & ~reset;
  assign alucontrol = reset ? 3'b000 : w_alucontrol;
  assign state      = r_state;

endmodule

// File: tb/tb_mips8_control_fsm.sv
// Self-checking bench for mips8_control_fsm. A reference model written from
// the instruction-level rules (per-class state paths and per-state control
// table) predicts every output on every cycle.
module tb_mips8_control_fsm;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LB    = 6'b100000;
  localparam logic [5:0] OP_SB    = 6'b101000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  logic       clk;
  logic       reset;
  logic [5:0] op;
  logic [5:0] funct;
  logic       zero;
  logic       memread, memwrite, alusrca, memtoreg, regdst, iord, regwrite;
  logic       pcen, branch;
  logic [1:0] alusrcb, pcsrc;
  logic [3:0] irwrite, state;
  logic [2:0] alucontrol;
  logic [23:0] obs;

  int tests = 0;
  int fails = 0;

  // Trace of one instruction, filled by run_instr
  logic [23:0] tr_obs [0:15];
  logic        tr_zero[0:15];

  mips8_control_fsm dut (
    .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
    .memread(memread), .memwrite(memwrite), .alusrca(alusrca),
    .alusrcb(alusrcb), .memtoreg(memtoreg), .regdst(regdst), .iord(iord),
    .regwrite(regwrite), .irwrite(irwrite), .pcsrc(pcsrc), .pcen(pcen),
    .branch(branch), .alucontrol(alucontrol), .state(state)
  );

  assign obs = {memread, memwrite, alusrca, alusrcb, memtoreg, regdst, iord,
                regwrite, irwrite, pcsrc, pcen, branch, alucontrol, state};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic int model_len(input logic [5:0] o);
    case (o)
      OP_LB:    return 8;
      OP_SB:    return 7;
      OP_RTYPE: return 7;
      OP_ADDI:  return 7;
      OP_BEQ:   return 6;
      OP_J:     return 6;
      default:  return 5;
    endcase
  endfunction

  // State number at cycle k of an instruction (k counts from FETCH1 = 0)
  function automatic int model_state(input logic [5:0] o, input int k);
    int t;
    t = k - 5;
    if (k < 5) return k;
    case (o)
      OP_LB:    return 5 + t;             // MEMADR, LBRD, LBWR
      OP_SB:    return (t == 0) ? 5 : 8;  // MEMADR, SBWR
      OP_RTYPE: return 9 + t;             // RTYPEEX, RTYPEWR
      OP_BEQ:   return 11;
      OP_J:     return 12;
      OP_ADDI:  return 13 + t;            // ADDIEX, ADDIWR
      default:  return 0;
    endcase
  endfunction

  function automatic logic [2:0] model_alu(input int s, input logic [5:0] f);
    if (s == 11) return 3'b110;
    if (s != 9) return 3'b010;
    case (f)
      6'b100000: return 3'b010;
      6'b100010: return 3'b110;
      6'b100100: return 3'b000;
      6'b100101: return 3'b001;
      6'b101010: return 3'b111;
      default:   return 3'b101;
    endcase
  endfunction

  function automatic logic [23:0] model_out(input int s, input logic [5:0] f,
                                            input logic z);
    logic mr, mw, asa, mtr, rd, io, rw, pw, pwc, pen;
    logic [1:0] asb, ps;
    logic [3:0] ir, st;
    mr  = (s <= 3) || (s == 6);
    mw  = (s == 8);
    asa = (s == 5) || (s == 9) || (s == 11) || (s == 13);
    asb = (s <= 3) ? 2'b01 : (s == 4) ? 2'b11 :
          ((s == 5) || (s == 13)) ? 2'b10 : 2'b00;
    mtr = (s == 7);
    rd  = (s == 10);
    io  = (s == 6) || (s == 8);
    rw  = (s == 7) || (s == 10) || (s == 14);
    ir  = (s <= 3) ? (4'b0001 << s) : 4'b0000;
    ps  = (s == 11) ? 2'b01 : (s == 12) ? 2'b10 : 2'b00;
    pw  = (s <= 3) || (s == 12);
    pwc = (s == 11);
    pen = pw | (pwc & z);
    st  = s[3:0];
    return {mr, mw, asa, asb, mtr, rd, io, rw, ir, ps, pen, pwc,
            model_alu(s, f), st};
  endfunction

  // ---------------- stimulus driver (no checking) ----------------
  // Starts in the cycle where the DUT sits in FETCH1; records samples for
  // k = 0..len, the last sample being the return to FETCH1.
  // zmode: 0/1 hold zero at that value, 2 randomise each cycle.
  task automatic run_instr(input logic [5:0] o, input logic [5:0] f,
                           input int zmode);
    int n;
    n = model_len(o);
    for (int k = 0; k <= n; k++) begin
      if (k > 0) @(negedge clk);
      op    = o;
      funct = f;
      zero  = (zmode == 2) ? 1'($urandom_range(0, 1)) : 1'(zmode);
      #1;
      tr_obs[k]  = obs;
      tr_zero[k] = zero;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    reset = 1'b1;
    op    = 6'b000000;
    funct = 6'b100000;
    zero  = 1'b1;
    repeat (2) begin
      @(posedge clk);
      #1;
      tests++;
      if (obs !== 24'h000000) begin
        fails++;
        $display("FAIL reset_hold: got %h expected %h", obs, 24'h000000);
      end
    end
    @(negedge clk);
    reset = 1'b0;
    #1;
    tests++;
    if ({state, memread, irwrite, pcen} !== {4'd0, 1'b1, 4'b0001, 1'b1}) begin
      fails++;
      $display("FAIL reset_release: got st=%0d mr=%b ir=%b pcen=%b expected st=0 mr=1 ir=0001 pcen=1",
               state, memread, irwrite, pcen);
    end
  endtask

  task automatic test_rtype(input logic [5:0] f, input string name);
    int n;
    logic [23:0] e;
    run_instr(OP_RTYPE, f, 2);
    n = model_len(OP_RTYPE);
    for (int k = 0; k <= n; k++) begin
      e = model_out((k == n) ? 0 : model_state(OP_RTYPE, k), f, tr_zero[k]);
      tests++;
      if (tr_obs[k] !== e) begin
        fails++;
        $display("FAIL %s k=%0d: got %h expected %h", name, k, tr_obs[k], e);
      end
    end
  endtask

  task automatic test_lb;
    int n;
    logic [23:0] e;
    run_instr(OP_LB, 6'($urandom), 2);
    n = model_len(OP_LB);
    for (int k = 0; k <= n; k++) begin
      e = model_out((k == n) ? 0 : model_state(OP_LB, k), 6'b000000, tr_zero[k]);
      tests++;
      if (tr_obs[k] !== e) begin
        fails++;
        $display("FAIL lb k=%0d: got %h expected %h", k, tr_obs[k], e);
      end
    end
  endtask

  task automatic test_sb;
    int n, wr_cycles;
    logic [23:0] e;
    run_instr(OP_SB, 6'($urandom), 2);
    n = model_len(OP_SB);
    wr_cycles = 0;
    for (int k = 0; k <= n; k++) begin
      if (k < n && tr_obs[k][22]) wr_cycles++;
      e = model_out((k == n) ? 0 : model_state(OP_SB, k), 6'b000000, tr_zero[k]);
      tests++;
      if (tr_obs[k] !== e) begin
        fails++;
        $display("FAIL sb k=%0d: got %h expected %h", k, tr_obs[k], e);
      end
    end
    tests++;
    if (wr_cycles !== 1) begin
      fails++;
      $display("FAIL sb_write_once: got %0d cycles expected 1", wr_cycles);
    end
  endtask

  task automatic test_beq(input int zval);
    int n;
    logic [23:0] e;
    run_instr(OP_BEQ, 6'($urandom), zval);
    n = model_len(OP_BEQ);
    for (int k = 0; k <= n; k++) begin
      e = model_out((k == n) ? 0 : model_state(OP_BEQ, k), 6'b000000, tr_zero[k]);
      tests++;
      if (tr_obs[k] !== e) begin
        fails++;
        $display("FAIL beq_z%0d k=%0d: got %h expected %h", zval, k, tr_obs[k], e);
      end
    end
  endtask

  task automatic test_jump_and_illegal;
    int n;
    logic [23:0] e;
    logic [5:0] ops[2];
    ops[0] = OP_J;
    ops[1] = 6'b111111;
    for (int i = 0; i < 2; i++) begin
      run_instr(ops[i], 6'($urandom), 2);
      n = model_len(ops[i]);
      for (int k = 0; k <= n; k++) begin
        e = model_out((k == n) ? 0 : model_state(ops[i], k), 6'b000000, tr_zero[k]);
        tests++;
        if (tr_obs[k] !== e) begin
          fails++;
          $display("FAIL op%b k=%0d: got %h expected %h", ops[i], k, tr_obs[k], e);
        end
      end
    end
  endtask

  task automatic test_random(input int count);
    int n;
    logic [5:0] o, f;
    logic [23:0] e;
    logic [5:0] legal[6];
    logic [5:0] functs[5];
    legal  = '{OP_RTYPE, OP_LB, OP_SB, OP_BEQ, OP_J, OP_ADDI};
    functs = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
    for (int i = 0; i < count; i++) begin
      o = ($urandom_range(0, 3) == 0) ? 6'($urandom) : legal[$urandom_range(0, 5)];
      f = ($urandom_range(0, 3) == 0) ? 6'($urandom) : functs[$urandom_range(0, 4)];
      run_instr(o, f, 2);
      n = model_len(o);
      for (int k = 0; k <= n; k++) begin
        e = model_out((k == n) ? 0 : model_state(o, k), f, tr_zero[k]);
        tests++;
        if (tr_obs[k] !== e) begin
          fails++;
          $display("FAIL rand%0d op=%b fn=%b k=%0d: got %h expected %h",
                   i, o, f, k, tr_obs[k], e);
        end
      end
    end
  endtask

  task automatic test_async_reset;
    int n;
    logic [23:0] e;
    op    = OP_SB;
    funct = 6'b000000;
    zero  = 1'b0;
    for (int k = 1; k <= 6; k++) @(negedge clk);
    #1;
    tests++;
    if ({state, memwrite} !== {4'd8, 1'b1}) begin
      fails++;
      $display("FAIL areset_pre: got st=%0d mw=%b expected st=8 mw=1", state, memwrite);
    end
    #2 reset = 1'b1;   // between clock edges
    #1;
    tests++;
    if (obs !== 24'h000000) begin
      fails++;
      $display("FAIL areset_immediate: got %h expected %h", obs, 24'h000000);
    end
    @(posedge clk);
    #1;
    tests++;
    if (obs !== 24'h000000) begin
      fails++;
      $display("FAIL areset_held: got %h expected %h", obs, 24'h000000);
    end
    @(negedge clk);
    reset = 1'b0;
    run_instr(OP_ADDI, 6'b000000, 2);
    n = model_len(OP_ADDI);
    for (int k = 0; k <= n; k++) begin
      e = model_out((k == n) ? 0 : model_state(OP_ADDI, k), 6'b000000, tr_zero[k]);
      tests++;
      if (tr_obs[k] !== e) begin
        fails++;
        $display("FAIL areset_restart k=%0d: got %h expected %h", k, tr_obs[k], e);
      end
    end
  endtask

  initial begin
    test_reset();
    test_rtype(6'b100000, "rtype_add");
    test_lb();
    test_sb();
    test_beq(1);
    test_beq(0);
    test_jump_and_illegal();
    test_rtype(6'b100101, "rtype_or");
    test_rtype(6'b101010, "rtype_slt");
    test_rtype(6'b000111, "rtype_bad_funct");
    test_random(60);
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mips8_control_fsm.md
Name: mips8_control_fsm

Overview:
- Multicycle main controller for the 8-bit MIPS datapath.
- Sequences the byte-wise instruction fetch (four 8-bit reads into the 32-bit IR), then decode, execute, memory and writeback.
- Drives every datapath mux/enable and the ALU control code; sits directly upstream of the datapath/memory block and consumes op/funct/zero from it.

Parameters:
- OP_RTYPE, 6'b000000, R-type opcode
- OP_LB, 6'b100000, load byte opcode
- OP_SB, 6'b101000, store byte opcode
- OP_BEQ, 6'b000100, branch-if-equal opcode
- OP_J, 6'b000010, jump opcode
- OP_ADDI, 6'b001000, add-immediate opcode

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- op  in  6  instr[31:26] from IR
- funct  in  6  instr[5:0] from IR
- zero  in  1  ALU zero flag
- memread  out  1  memory read strobe
- memwrite  out  1  memory write strobe
- alusrca  out  1  0=PC, 1=regA
- alusrcb  out  2  00=regB, 01=const 1, 10=imm, 11=imm (branch offset)
- memtoreg  out  1  regfile write data: 0=ALUout, 1=MDR
- regdst  out  1  write reg: 0=rt, 1=rd
- iord  out  1  memory address: 0=PC, 1=ALUout
- regwrite  out  1  regfile write enable
- irwrite  out  4  one-hot IR byte load enable
- pcsrc  out  2  00=ALU result, 01=ALUout, 10=jump target
- pcen  out  1  PC load enable
- branch  out  1  pcwritecond (BEQEX state only)
- alucontrol  out  3  ALU operation code
- state  out  4  current state encoding (debug)

Behaviour:
State encoding:
- FETCH1=0, FETCH2=1, FETCH3=2, FETCH4=3, DECODE=4
- MEMADR=5, LBRD=6, LBWR=7, SBWR=8
- RTYPEEX=9, RTYPEWR=10, BEQEX=11, JEX=12, ADDIEX=13, ADDIWR=14
- Code 15 is unused and returns to FETCH1 on the next edge.

Reset:
- reset=1 forces state=FETCH1 immediately, without waiting for clk.
- While reset=1, every output is 0 except state=0.
- Reset mid-instruction aborts the instruction; no write strobe may be asserted while reset is held.

Output decoding:
- Outputs are Moore, combinational from state, except pcen.
- pcen = pcwrite | (pcwritecond & zero); it is combinational on zero.

Transitions (one per rising clk edge):
- FETCH1 -> FETCH2 -> FETCH3 -> FETCH4 -> DECODE.
- DECODE -> by op: LB/SB->MEMADR, RTYPE->RTYPEEX, BEQ->BEQEX, J->JEX, ADDI->ADDIEX, other->FETCH1.
- MEMADR -> LBRD if op=LB, else SBWR.
- LBRD -> LBWR.
- RTYPEEX -> RTYPEWR.
- ADDIEX -> ADDIWR.
- LBWR, SBWR, RTYPEWR, BEQEX, JEX, ADDIWR -> FETCH1.

Per-state assertions (unlisted outputs are 0; aluop 00 unless stated):
- FETCHn: memread=1, alusrcb=01, pcwrite=1, irwrite=1<<(n-1).
- DECODE: alusrcb=11.
- MEMADR: alusrca=1, alusrcb=10.
- LBRD: memread=1, iord=1.
- LBWR: regwrite=1, memtoreg=1.
- SBWR: memwrite=1, iord=1.
- RTYPEEX: alusrca=1, aluop=10.
- RTYPEWR: regwrite=1, regdst=1.
- BEQEX: alusrca=1, aluop=01, pcwritecond=1, pcsrc=01.
- JEX: pcwrite=1, pcsrc=10.
- ADDIEX: alusrca=1, alusrcb=10.
- ADDIWR: regwrite=1.

ALU decode:
- aluop 00 -> alucontrol 010 (add).
- aluop 01 -> 110 (sub).
- aluop 10, decoded by funct: 100000->010, 100010->110, 100100->000, 100101->001, 101010->111, any other funct->101.

Latency (cycles per instruction):
- LB=8, SB=7, RTYPE=7, ADDI=7, BEQ=6, J=6, illegal op=5.

Test Plan:
- Reset held 2 cycles, then released with op=0, funct=100000: state=0, memread=1, irwrite=0001, pcen=1. Next edges give irwrite 0010, 0100, 1000, then DECODE with alusrcb=11. RTYPEEX shows alucontrol=010, alusrca=1; RTYPEWR shows regwrite=1, regdst=1; the 7th edge returns to FETCH1.
- op=100000 (LB): MEMADR (alusrcb=10) -> LBRD (memread=1, iord=1) -> LBWR (regwrite=1, memtoreg=1) -> FETCH1; 8 cycles total, memwrite never 1.
- op=101000 (SB): MEMADR -> SBWR with memwrite=1, iord=1 for exactly one cycle -> FETCH1.
- op=000100 (BEQ), zero=1 in BEQEX: branch=1, pcen=1, pcsrc=01, alucontrol=110. Repeat with zero=0: branch=1, pcen=0.
- Other directed cases:
  - op=000010 (J): JEX gives pcen=1, pcsrc=10.
  - op=111111: DECODE -> FETCH1 with no write strobes.
  - funct=100101 -> alucontrol=001; funct=101010 -> 111; funct=000111 -> 101.
- Assert reset asynchronously between clock edges while in SBWR: state=0 and memwrite=0 immediately, before the next clk edge. After release, the fetch restarts at FETCH1.
